// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl
//   PC sequencer for the multi-cycle reference CPU. Offers one PC at a time
//   to fetch, waits for that instruction to retire, then selects the next PC.
//   After a branch/jump retires, the delay slot at branch_pc+4 issues next and
//   the branch's resolved PC follows. Exceptions redirect to a vector and
//   capture EPC/BD for CP0.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   issue_valid      out  pc is offered to fetch (Moore, registered)
//   issue_ready      in   fetch accepts pc (handshake when both high)
//   pc               out  PC of the offered / in-flight instruction
//   in_slot          out  offered / in-flight instruction is a delay slot
//   retire_valid     in   in-flight instruction completed (1-cycle pulse)
//   retire_is_branch in   retiring instruction is a branch/jump
//   retire_new_pc    in   resolved next PC of the retiring branch
//   exc_valid        in   in-flight instruction raised an exception (pulse)
//   exc_vec          in   exception handler address
//   exc_epc          out  EPC captured at the last exception
//   exc_bd           out  BD bit captured at the last exception
//   slot_err         out  1-cycle pulse: branch retired inside a delay slot
module branch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] pc,
  output logic        in_slot,
  input  logic        retire_valid,
  input  logic        retire_is_branch,
  input  logic [31:0] retire_new_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_vec,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        slot_err
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        issue_valid_q, issue_valid_d;
  logic [31:0] pc_q, pc_d;
  logic        in_slot_q, in_slot_d;
  logic        pend_q, pend_d;
  logic [31:0] target_q, target_d;
  logic [31:0] bpc_q, bpc_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic        slot_err_q, slot_err_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    in_slot_d  = in_slot_q;
    pend_d     = pend_q;
    target_d   = target_q;
    bpc_d      = bpc_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    slot_err_d = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        // pc stays put until fetch takes it, and is held while in flight.
        if (issue_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (exc_valid) begin
          // Exception wins over a same-cycle retire. A faulting delay slot
          // reports its branch as EPC so the handler can re-run the branch.
          state_d   = S_ISSUE;
          epc_d     = in_slot_q ? bpc_q : pc_q;
          bd_d      = in_slot_q;
          pc_d      = exc_vec;
          pend_d    = 1'b0;
          in_slot_d = 1'b0;
        end else if (retire_valid) begin
          state_d = S_ISSUE;
          if (!pend_q) begin
            pc_d = pc_q + 32'd4;
            if (retire_is_branch) begin
              bpc_d     = pc_q;
              target_d  = retire_new_pc;
              pend_d    = 1'b1;
              in_slot_d = 1'b1;
            end
          end else begin
            // Delay slot done: jump to the owed target. A branch sitting in
            // the slot is flagged and its own resolved PC dropped.
            pc_d       = target_q;
            pend_d     = 1'b0;
            in_slot_d  = 1'b0;
            slot_err_d = retire_is_branch;
          end
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    issue_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      issue_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      in_slot_q     <= 1'b0;
      pend_q        <= 1'b0;
      target_q      <= 32'd0;
      bpc_q         <= 32'd0;
      epc_q         <= 32'd0;
      bd_q          <= 1'b0;
      slot_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      pc_q          <= pc_d;
      in_slot_q     <= in_slot_d;
      pend_q        <= pend_d;
      target_q      <= target_d;
      bpc_q         <= bpc_d;
      epc_q         <= epc_d;
      bd_q          <= bd_d;
      slot_err_q    <= slot_err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign pc          = pc_q;
  assign in_slot     = in_slot_q;
  assign exc_epc     = epc_q;
  assign exc_bd      = bd_q;
  assign slot_err    = slot_err_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
module tb_branch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] pc;
  logic        in_slot;
  logic        retire_valid;
  logic        retire_is_branch;
  logic [31:0] retire_new_pc;
  logic        exc_valid;
  logic [31:0] exc_vec;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        slot_err;

  int checks   = 0;
  int failures = 0;

  branch_seq_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .pc               (pc),
    .in_slot          (in_slot),
    .retire_valid     (retire_valid),
    .retire_is_branch (retire_is_branch),
    .retire_new_pc    (retire_new_pc),
    .exc_valid        (exc_valid),
    .exc_vec          (exc_vec),
    .exc_epc          (exc_epc),
    .exc_bd           (exc_bd),
    .slot_err         (slot_err)
  );

  always #5 clk = ~clk;

  // Reference model: transaction view of the sequencer.
  // booting   : first cycle after reset, nothing offered yet
  // offering  : current PC is being offered to fetch
  // otherwise : current PC is in flight, awaiting retire/exception
  // owed      : resolved PCs owed after a delay slot (at most one)
  bit          m_booting;
  bit          m_offering;
  logic [31:0] m_pc;
  logic [31:0] m_branch_pc;
  logic [31:0] owed[$];
  logic [31:0] m_epc;
  bit          m_bd;
  bit          m_slot_err;

  function automatic void model_reset();
    m_booting   = 1'b1;
    m_offering  = 1'b0;
    m_pc        = 32'hbfc0_0000;
    m_branch_pc = 32'd0;
    owed.delete();
    m_epc       = 32'd0;
    m_bd        = 1'b0;
    m_slot_err  = 1'b0;
  endfunction

  function automatic void model_clock();
    bit in_delay_slot;
    in_delay_slot = (owed.size() != 0);
    m_slot_err = 1'b0;
    if (m_booting) begin
      m_booting  = 1'b0;
      m_offering = 1'b1;
    end else if (m_offering) begin
      if (issue_ready) m_offering = 1'b0;
    end else if (exc_valid) begin
      m_epc = in_delay_slot ? m_branch_pc : m_pc;
      m_bd  = in_delay_slot;
      m_pc  = exc_vec;
      owed.delete();
      m_offering = 1'b1;
    end else if (retire_valid) begin
      m_offering = 1'b1;
      if (in_delay_slot) begin
        m_slot_err = retire_is_branch;
        m_pc = owed.pop_front();
      end else begin
        if (retire_is_branch) begin
          m_branch_pc = m_pc;
          owed.push_back(retire_new_pc);
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".issue_valid"}, {31'd0, issue_valid}, {31'd0, m_offering});
    chk({tag, ".pc"},          pc,                   m_pc);
    chk({tag, ".in_slot"},     {31'd0, in_slot},     {31'd0, owed.size() != 0});
    chk({tag, ".exc_epc"},     exc_epc,              m_epc);
    chk({tag, ".exc_bd"},      {31'd0, exc_bd},      {31'd0, m_bd});
    chk({tag, ".slot_err"},    {31'd0, slot_err},    {31'd0, m_slot_err});
  endtask

  task automatic clear_inputs();
    issue_ready      = 1'b0;
    retire_valid     = 1'b0;
    retire_is_branch = 1'b0;
    retire_new_pc    = 32'd0;
    exc_valid        = 1'b0;
    exc_vec          = 32'd0;
  endtask

  // One clock with the currently driven inputs; inputs change 1 ns after the edge.
  task automatic tick(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    clear_inputs();
    check_all(tag);
  endtask

  task automatic handshake(input string tag);
    issue_ready = 1'b1;
    tick(tag);
  endtask

  task automatic retire(input string tag, input bit br, input logic [31:0] npc);
    retire_valid = 1'b1; retire_is_branch = br; retire_new_pc = npc;
    tick(tag);
  endtask

  task automatic raise_exc(input string tag, input logic [31:0] vec, input bit also_retire);
    exc_valid = 1'b1; exc_vec = vec; retire_valid = also_retire;
    tick(tag);
  endtask

  task automatic boot_sequence(input string tag);
    // Reset released 1 ns after an edge: nothing offered yet.
    check_all({tag, "_rel"});
    chk({tag, "_rel_pc"}, pc, 32'hbfc0_0000);
    chk({tag, "_rel_iv"}, {31'd0, issue_valid}, 32'd0);
    for (int i = 0; i < 3; i++) tick({tag, "_hold"});
    chk({tag, "_hold_iv"}, {31'd0, issue_valid}, 32'd1);
    chk({tag, "_hold_pc"}, pc, 32'hbfc0_0000);
    handshake({tag, "_hs"});
    chk({tag, "_hs_iv"}, {31'd0, issue_valid}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: boot and first handshake
    boot_sequence("t1");

    // 2: sequential, including 32-bit wrap
    retire("t2_seq", 1'b0, 32'd0);
    chk("t2_seq_pc", pc, 32'hbfc0_0004);
    handshake("t2_hs");
    raise_exc("t2_exc", 32'hffff_fffc, 1'b0);
    handshake("t2_hs2");
    retire("t2_wrap", 1'b0, 32'd0);
    chk("t2_wrap_pc", pc, 32'h0000_0000);

    // 3: taken and not-taken branches
    handshake("t3_hs0");
    raise_exc("t3_goto", 32'h0000_0100, 1'b0);
    handshake("t3_hs1");
    retire("t3_br", 1'b1, 32'h0000_0200);
    chk("t3_br_pc", pc, 32'h0000_0104);
    handshake("t3_hs2");
    retire("t3_slot", 1'b0, 32'd0);
    chk("t3_taken_pc", pc, 32'h0000_0200);
    handshake("t3_hs3");
    raise_exc("t3_goto2", 32'h0000_0100, 1'b0);
    handshake("t3_hs4");
    retire("t3_br2", 1'b1, 32'h0000_0108);
    handshake("t3_hs5");
    retire("t3_slot2", 1'b0, 32'd0);
    chk("t3_nt_pc", pc, 32'h0000_0108);

    // 4: exception in delay slot, with simultaneous retire
    handshake("t4_hs0");
    raise_exc("t4_goto", 32'h0000_0100, 1'b0);
    handshake("t4_hs1");
    retire("t4_br", 1'b1, 32'h0000_0200);
    handshake("t4_hs2");
    raise_exc("t4_exc", 32'hbfc0_0380, 1'b1);
    chk("t4_epc", exc_epc, 32'h0000_0100);
    chk("t4_bd", {31'd0, exc_bd}, 32'd1);
    handshake("t4_hs3");
    retire("t4_next", 1'b0, 32'd0);
    chk("t4_next_pc", pc, 32'hbfc0_0384);

    // 5: branch in delay slot
    handshake("t5_hs0");
    raise_exc("t5_goto", 32'h0000_0100, 1'b0);
    handshake("t5_hs1");
    retire("t5_br", 1'b1, 32'h0000_0200);
    handshake("t5_hs2");
    retire("t5_br_in_slot", 1'b1, 32'h0000_0300);
    chk("t5_slot_err", {31'd0, slot_err}, 32'd1);
    chk("t5_pc", pc, 32'h0000_0200);
    handshake("t5_after");
    chk("t5_slot_err_drop", {31'd0, slot_err}, 32'd0);

    // 6: asynchronous reset while waiting with a slot owed
    raise_exc("t6_goto", 32'h0000_0100, 1'b0);
    handshake("t6_hs1");
    retire("t6_br", 1'b1, 32'h0000_0200);
    handshake("t6_hs2");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t6_async");
    @(posedge clk); #1;
    reset = 1'b0;
    boot_sequence("t6");

    // Randomized traffic, including retire/exception pulses outside the wait phase
    for (int i = 0; i < 400; i++) begin
      issue_ready      = ($urandom_range(0, 1) == 1);
      retire_valid     = ($urandom_range(0, 9) < 4);
      retire_is_branch = ($urandom_range(0, 9) < 4);
      retire_new_pc    = $urandom;
      exc_valid        = ($urandom_range(0, 11) == 0);
      exc_vec          = $urandom;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
